// File: rtl/prefetch_queue.sv
// prefetch_queue: buffers line-aligned prefetch hints from the tile prefetcher and issues them to
// the cache over a valid/ready handshake.
//   - Hints are staged for one cycle, then checked against queued lines and a small FIFO of
//     recently issued lines. A match is discarded as a duplicate, and a hint arriving at a full
//     queue is dropped. The prefetcher is never back-pressured.
//   - Duplicate and drop events are counted by saturating counters.
//   - A register bus controls enable and clears the statistics.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   prefetch_valid/addr         hint stream in (always accepted)
//   pf_req_valid/ready/addr     line-aligned request out
//   reg_bus_wvalid/waddr/wdata  register write port
//   drop_count, dedup_count     saturating statistics
//   occupancy                   current queue entries
module prefetch_queue #(
  parameter int unsigned DEPTH                    = 8,
  parameter int unsigned FILTER                   = 4,
  parameter int unsigned LINE_BITS                = 6,
  parameter logic [31:0] PREFETCH_QUEUE_ENABLE    = 32'h0000_0000,
  parameter logic [31:0] PREFETCH_QUEUE_CLR_STATS = 32'h0000_0004,
  localparam int unsigned OCC_W                   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             prefetch_valid,
  input  logic [63:0]      prefetch_addr,
  output logic             pf_req_valid,
  input  logic             pf_req_ready,
  output logic [63:0]      pf_req_addr,
  input  logic             reg_bus_wvalid,
  input  logic [31:0]      reg_bus_waddr,
  input  logic [31:0]      reg_bus_wdata,
  output logic [31:0]      drop_count,
  output logic [31:0]      dedup_count,
  output logic [OCC_W-1:0] occupancy
);

  localparam int unsigned TW  = 64 - LINE_BITS;
  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned FPW = (FILTER > 1) ? $clog2(FILTER) : 1;
  localparam logic [FPW-1:0]   FiltLast = FPW'(FILTER - 1);
  localparam logic [OCC_W-1:0] OccFull  = OCC_W'(DEPTH);

  logic              enable_q;
  logic              stage_vld_q;
  logic [TW-1:0]     stage_tag_q;
  logic [TW-1:0]     q_tag_q [DEPTH];
  logic [DEPTH-1:0]  q_vld_q;
  logic [PW-1:0]     head_q, tail_q;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [TW-1:0]     f_tag_q [FILTER];
  logic [FILTER-1:0] f_vld_q;
  logic [FPW-1:0]    f_ptr_q;
  logic [31:0]       drop_q, dedup_q;

  logic          en_wr, clr_wr, flush;
  logic          pop, push, full, match, is_dup, is_drop;
  logic [TW-1:0] head_tag;
  logic          unused_bits;

  assign unused_bits = ^{reg_bus_wdata[31:1], prefetch_addr[LINE_BITS-1:0]};

  assign en_wr  = reg_bus_wvalid && (reg_bus_waddr == PREFETCH_QUEUE_ENABLE);
  assign clr_wr = reg_bus_wvalid && (reg_bus_waddr == PREFETCH_QUEUE_CLR_STATS);
  // Disabling flushes all hint state; nothing staged in that cycle is acted on or counted.
  assign flush  = en_wr && !reg_bus_wdata[0];

  assign head_tag     = q_tag_q[head_q];
  assign pf_req_valid = enable_q && (occ_q != '0);
  assign pf_req_addr  = pf_req_valid ? {head_tag, {LINE_BITS{1'b0}}} : 64'h0;
  assign pop          = pf_req_valid && pf_req_ready;
  assign full         = (occ_q == OccFull);

  // The head is still valid while being popped, so it participates in the match.
  always_comb begin
    match = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q_vld_q[i] && (q_tag_q[i] == stage_tag_q)) match = 1'b1;
    end
    for (int j = 0; j < FILTER; j++) begin
      if (f_vld_q[j] && (f_tag_q[j] == stage_tag_q)) match = 1'b1;
    end
  end

  assign is_dup  = stage_vld_q && !flush && match;
  assign is_drop = stage_vld_q && !flush && !match && full && !pop;
  assign push    = stage_vld_q && !flush && !match && (!full || pop);

  always_comb begin
    occ_d = occ_q;
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      enable_q    <= 1'b1;
      stage_vld_q <= 1'b0;
      stage_tag_q <= '0;
      q_vld_q     <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      occ_q       <= '0;
      f_vld_q     <= '0;
      f_ptr_q     <= '0;
      drop_q      <= '0;
      dedup_q     <= '0;
    end else begin
      if (en_wr) enable_q <= reg_bus_wdata[0];
      stage_vld_q <= prefetch_valid && enable_q && !flush;
      if (prefetch_valid) stage_tag_q <= prefetch_addr[63:LINE_BITS];

      if (flush) begin
        q_vld_q <= '0;
        head_q  <= '0;
        tail_q  <= '0;
        occ_q   <= '0;
        f_vld_q <= '0;
        f_ptr_q <= '0;
      end else begin
        // Pop before push: on full+pop+push head equals tail and the slot must stay valid.
        if (pop) begin
          q_vld_q[head_q]  <= 1'b0;
          head_q           <= head_q + PW'(1);
          f_vld_q[f_ptr_q] <= 1'b1;
          f_ptr_q          <= (f_ptr_q == FiltLast) ? '0 : f_ptr_q + FPW'(1);
        end
        if (push) begin
          q_vld_q[tail_q] <= 1'b1;
          tail_q          <= tail_q + PW'(1);
        end
        occ_q <= occ_d;
      end

      // A clear in the same cycle as an increment wins.
      if (clr_wr) begin
        drop_q  <= '0;
        dedup_q <= '0;
      end else begin
        if (is_drop && (drop_q != 32'hFFFF_FFFF)) drop_q <= drop_q + 32'd1;
        if (is_dup && (dedup_q != 32'hFFFF_FFFF)) dedup_q <= dedup_q + 32'd1;
      end
    end
  end

  // Tag storage needs no reset; validity is tracked separately.
  always_ff @(posedge clk) begin
    if (push) q_tag_q[tail_q] <= stage_tag_q;
    if (pop) f_tag_q[f_ptr_q] <= head_tag;
  end

  assign drop_count  = drop_q;
  assign dedup_count = dedup_q;
  assign occupancy   = occ_q;

endmodule

// File: tb/tb_prefetch_queue.sv
module tb_prefetch_queue;

  localparam int unsigned DEPTH = 8;
  localparam logic [31:0] A_EN  = 32'h0000_0000;
  localparam logic [31:0] A_CLR = 32'h0000_0004;

  logic        clk = 1'b0;
  logic        rst;
  logic        pv;
  logic [63:0] paddr;
  logic        rq_valid;
  logic        rdy;
  logic [63:0] rq_addr;
  logic        wv;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic [31:0] drop_count;
  logic [31:0] dedup_count;
  logic [3:0]  occupancy;

  int n_cmp = 0;
  int n_err = 0;

  prefetch_queue #(
    .DEPTH    (DEPTH),
    .FILTER   (4),
    .LINE_BITS(6)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .prefetch_valid(pv),
    .prefetch_addr (paddr),
    .pf_req_valid  (rq_valid),
    .pf_req_ready  (rdy),
    .pf_req_addr   (rq_addr),
    .reg_bus_wvalid(wv),
    .reg_bus_waddr (waddr),
    .reg_bus_wdata (wdata),
    .drop_count    (drop_count),
    .dedup_count   (dedup_count),
    .occupancy     (occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pv;
    logic [63:0] addr;
    logic        rdy;
    logic        ev;
    logic [63:0] ea;
    int          eocc;
    int          edd;
    int          edr;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Starts a new cycle: inputs driven here are sampled at the next posedge, and the outputs
  // seen right after reflect state during this cycle.
  task automatic cyc(input logic v, input logic [63:0] a);
    @(negedge clk);
    pv    = v;
    paddr = a;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; pv = 1'b0; paddr = '0; rdy = 1'b0; wv = 1'b0; waddr = '0; wdata = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic        seen;
    logic [63:0] got;
    logic [63:0] exp_a;

    // Single hint, duplicate against queue, duplicate against filter.
    vecs[0]  = '{1'b1, 64'h1234, 1'b1, 1'b0, 64'h0,    0, 0, 0};
    vecs[1]  = '{1'b0, 64'h0,    1'b1, 1'b0, 64'h0,    0, 0, 0};
    vecs[2]  = '{1'b0, 64'h0,    1'b1, 1'b1, 64'h1200, 1, 0, 0};
    vecs[3]  = '{1'b0, 64'h0,    1'b0, 1'b0, 64'h0,    0, 0, 0};
    vecs[4]  = '{1'b1, 64'h1000, 1'b0, 1'b0, 64'h0,    0, 0, 0};
    vecs[5]  = '{1'b1, 64'h1010, 1'b0, 1'b0, 64'h0,    0, 0, 0};
    vecs[6]  = '{1'b0, 64'h0,    1'b0, 1'b1, 64'h1000, 1, 0, 0};
    vecs[7]  = '{1'b0, 64'h0,    1'b0, 1'b1, 64'h1000, 1, 1, 0};
    vecs[8]  = '{1'b1, 64'h1238, 1'b0, 1'b1, 64'h1000, 1, 1, 0};
    vecs[9]  = '{1'b0, 64'h0,    1'b0, 1'b1, 64'h1000, 1, 1, 0};
    vecs[10] = '{1'b0, 64'h0,    1'b1, 1'b1, 64'h1000, 1, 2, 0};
    vecs[11] = '{1'b0, 64'h0,    1'b0, 1'b0, 64'h0,    0, 2, 0};

    rst = 1'b1; pv = 1'b0; paddr = '0; rdy = 1'b0; wv = 1'b0; waddr = '0; wdata = '0;
    do_reset();
    check("reset valid", 64'(rq_valid), 64'd0);
    check("reset addr", rq_addr, 64'd0);
    check("reset occ", 64'(occupancy), 64'd0);
    check("reset dedup", 64'(dedup_count), 64'd0);
    check("reset drop", 64'(drop_count), 64'd0);

    for (int i = 0; i < 12; i++) begin
      cyc(vecs[i].pv, vecs[i].addr);
      rdy = vecs[i].rdy;
      check($sformatf("vec%0d valid", i), 64'(rq_valid), 64'(vecs[i].ev));
      check($sformatf("vec%0d addr", i), rq_addr, vecs[i].ea);
      check($sformatf("vec%0d occ", i), 64'(occupancy), 64'(vecs[i].eocc));
      check($sformatf("vec%0d dedup", i), 64'(dedup_count), 64'(vecs[i].edd));
      check($sformatf("vec%0d drop", i), 64'(drop_count), 64'(vecs[i].edr));
    end

    // Filter hit, then eviction after FILTER+1 further lines.
    do_reset();
    rdy = 1'b1;
    cyc(1'b1, 64'h2000);
    repeat (3) cyc(1'b0, 64'h0);
    cyc(1'b1, 64'h2008);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 64'h0);
      check("filter hit no req", 64'(rq_valid), 64'd0);
    end
    check("filter hit dedup", 64'(dedup_count), 64'd1);
    for (int j = 0; j < 5; j++) begin
      cyc(1'b1, 64'h3000 + 64'(j) * 64'h40);
      repeat (3) cyc(1'b0, 64'h0);
    end
    check("evict dedup unchanged", 64'(dedup_count), 64'd1);
    cyc(1'b1, 64'h2000);
    seen = 1'b0;
    got  = '0;
    for (int k = 0; k < 6; k++) begin
      cyc(1'b0, 64'h0);
      if (rq_valid) begin
        seen = 1'b1;
        got  = rq_addr;
        break;
      end
    end
    check("reissue valid", 64'(seen), 64'd1);
    check("reissue addr", got, 64'h2000);

    // Overflow with DEPTH+3 distinct lines.
    do_reset();
    rdy = 1'b0;
    for (int i = 0; i < DEPTH + 3; i++) cyc(1'b1, 64'h4000 + 64'(i) * 64'h40);
    repeat (2) cyc(1'b0, 64'h0);
    check("ovf occ", 64'(occupancy), 64'(DEPTH));
    check("ovf drop", 64'(drop_count), 64'd3);
    check("ovf head", rq_addr, 64'h4000);
    check("ovf dedup", 64'(dedup_count), 64'd0);

    // Full queue: new hint in stage 1 in the same cycle as a pop.
    cyc(1'b1, 64'h9000);
    cyc(1'b0, 64'h0);
    rdy = 1'b1;
    cyc(1'b0, 64'h0);
    rdy = 1'b0;
    check("fullpop occ", 64'(occupancy), 64'(DEPTH));
    check("fullpop drop", 64'(drop_count), 64'd3);
    check("fullpop head", rq_addr, 64'h4040);
    for (int j = 0; j < DEPTH; j++) begin
      cyc(1'b0, 64'h0);
      rdy   = 1'b1;
      exp_a = (j < DEPTH - 1) ? 64'h4040 + 64'(j) * 64'h40 : 64'h9000;
      check($sformatf("drain%0d valid", j), 64'(rq_valid), 64'd1);
      check($sformatf("drain%0d addr", j), rq_addr, exp_a);
    end
    cyc(1'b0, 64'h0);
    rdy = 1'b0;
    check("drained occ", 64'(occupancy), 64'd0);
    cyc(1'b0, 64'h0);
    wv = 1'b1; waddr = A_CLR; wdata = '0;
    cyc(1'b0, 64'h0);
    wv = 1'b0;
    check("clr drop", 64'(drop_count), 64'd0);

    // Register control.
    do_reset();
    rdy = 1'b1;
    cyc(1'b1, 64'h6000);
    repeat (3) cyc(1'b0, 64'h0);
    rdy = 1'b0;
    cyc(1'b1, 64'h7000);
    cyc(1'b1, 64'h7040);
    cyc(1'b1, 64'h7080);
    cyc(1'b0, 64'h0);
    cyc(1'b0, 64'h0);
    check("ctl occ3", 64'(occupancy), 64'd3);
    cyc(1'b0, 64'h0);
    wv = 1'b1; waddr = 32'h8; wdata = '0;
    cyc(1'b0, 64'h0);
    wv = 1'b0;
    check("other addr ignored occ", 64'(occupancy), 64'd3);
    check("other addr ignored valid", 64'(rq_valid), 64'd1);
    cyc(1'b0, 64'h0);
    wv = 1'b1; waddr = A_EN; wdata = 32'h0;
    cyc(1'b0, 64'h0);
    wv = 1'b0;
    check("disable valid", 64'(rq_valid), 64'd0);
    check("disable occ", 64'(occupancy), 64'd0);
    cyc(1'b1, 64'h5000);
    repeat (3) cyc(1'b0, 64'h0);
    check("disabled hint occ", 64'(occupancy), 64'd0);
    check("disabled hint dedup", 64'(dedup_count), 64'd0);
    check("disabled hint drop", 64'(drop_count), 64'd0);
    cyc(1'b0, 64'h0);
    wv = 1'b1; waddr = A_EN; wdata = 32'h1;
    cyc(1'b0, 64'h0);
    wv = 1'b0;
    cyc(1'b1, 64'h6000);
    cyc(1'b0, 64'h0);
    cyc(1'b0, 64'h0);
    check("filter flushed occ", 64'(occupancy), 64'd1);
    check("filter flushed addr", rq_addr, 64'h6000);
    check("filter flushed dedup", 64'(dedup_count), 64'd0);
    cyc(1'b1, 64'h6010);
    cyc(1'b0, 64'h0);
    cyc(1'b0, 64'h0);
    check("pre-clear dedup", 64'(dedup_count), 64'd1);
    cyc(1'b0, 64'h0);
    wv = 1'b1; waddr = A_CLR;
    cyc(1'b0, 64'h0);
    wv = 1'b0;
    check("clear dedup", 64'(dedup_count), 64'd0);
    check("clear drop", 64'(drop_count), 64'd0);
    cyc(1'b1, 64'h6020);
    cyc(1'b0, 64'h0);
    wv = 1'b1; waddr = A_CLR;
    cyc(1'b0, 64'h0);
    wv = 1'b0;
    cyc(1'b0, 64'h0);
    check("clear wins dedup", 64'(dedup_count), 64'd0);
    check("clear wins occ", 64'(occupancy), 64'd1);

    // Reset mid-operation with a queued entry and a staged hint.
    cyc(1'b1, 64'h7100);
    cyc(1'b0, 64'h0);
    rst = 1'b1;
    cyc(1'b0, 64'h0);
    rst = 1'b0;
    check("midrst valid", 64'(rq_valid), 64'd0);
    check("midrst addr", rq_addr, 64'd0);
    check("midrst occ", 64'(occupancy), 64'd0);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 64'h0);
      check("midrst stays idle", 64'(rq_valid), 64'd0);
    end
    cyc(1'b1, 64'h7200);
    cyc(1'b0, 64'h0);
    cyc(1'b0, 64'h0);
    check("post-rst valid", 64'(rq_valid), 64'd1);
    check("post-rst addr", rq_addr, 64'h7200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/prefetch_queue.md
Name: prefetch_queue

Overview:
- Sits directly downstream of the per-tile prefetcher. Consumes its prefetch_valid/prefetch_addr stream and issues line-aligned prefetch requests to the L1/L2 with a valid/ready handshake.
- Buffers requests in a small FIFO. Suppresses duplicates against queued lines and recently issued lines.
- Drops requests when full, since prefetches are hints and the prefetcher is never back-pressured.
- Exposes drop and dedup statistics and a register-bus enable.

Parameters:
DEPTH, 8, queue entries (power of 2, >=2)
FILTER, 4, number of recently issued line addresses retained for dedup (>=1)
LINE_BITS, 6, log2 of cache line size in bytes

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
prefetch_valid  input  1  prefetch hint valid this cycle (no ready; always accepted)
prefetch_addr  input  64  byte address of hint
pf_req_valid  output  1  request to cache valid
pf_req_ready  input  1  cache accepts request
pf_req_addr  output  64  line-aligned request address (low LINE_BITS bits zero)
reg_bus_wvalid  input  1  register write strobe
reg_bus_waddr  input  32  register write address
reg_bus_wdata  input  32  register write data
drop_count  output  32  hints dropped because queue full, saturating
dedup_count  output  32  hints discarded as duplicates, saturating
occupancy  output  $clog2(DEPTH+1)  current queue entries

Behaviour:
- Reset (rst=1 at posedge):
  - queue and filter empty; staging register invalid
  - pf_req_valid=0, pf_req_addr=0
  - drop_count=0, dedup_count=0, occupancy=0
  - enable=1
- Line tag = prefetch_addr[63:LINE_BITS]. pf_req_addr = {head_tag, LINE_BITS'b0}.
- Stage 0: if prefetch_valid && enable at posedge, capture tag into the staging register (valid bit set). Otherwise the staging valid bit clears.
- Stage 1 (cycle after capture), with a valid staged tag:
  - Match = tag equals any valid queue entry (including the head being popped this cycle) OR any valid filter entry.
  - Match -> discard; dedup_count++.
  - Else if occupancy==DEPTH and no pop this cycle -> discard; drop_count++.
  - Else -> write at tail. A pop in the same cycle frees a slot, so a full queue with a pop accepts the write.
- Latency: hint at cycle t -> pf_req_valid earliest in cycle t+2, when the queue was empty.
- Output:
  - pf_req_valid = enable && occupancy!=0.
  - pf_req_addr is held stable while valid && !ready.
  - Pop on pf_req_valid && pf_req_ready.
- Filter:
  - On each pop, the popped tag enters the filter FIFO, replacing the oldest entry once FILTER entries are valid.
  - Filter entries are never invalidated except by reset or disable.
- Occupancy: +1 on write only, -1 on pop only, unchanged on simultaneous write+pop.
- Counters:
  - Saturate at 32'hFFFF_FFFF.
  - Dedup takes priority over drop; a single hint increments at most one counter.
- Register bus (address constants live in the shared header):
  - PREFETCH_QUEUE_ENABLE: enable <= wdata[0]. Writing 0 flushes the queue, the filter and the staging register in the same edge; counters are kept. While disabled, hints are ignored and not counted.
  - PREFETCH_QUEUE_CLR_STATS: drop_count and dedup_count <= 0. A counter increment in the same cycle is lost; the clear wins.
  - Other addresses are ignored.
- Reset mid-operation discards all queued and staged hints; no request is issued afterwards until a new hint arrives.
- Pointers wrap modulo DEPTH. Full and empty are distinguished by the occupancy counter.

Test Plan:
- Single hint, ready=1: prefetch_addr=0x1234 at cycle 0 -> pf_req_valid=1 with pf_req_addr=0x1200 in cycle 2; one cycle of valid only.
- Back-to-back duplicates, ready=0: addresses 0x1000 then 0x1010 -> occupancy=1, dedup_count=1.
- Filter hit: issue line 0x2000 with ready=1 until popped; rehint 0x2008 -> no request, dedup_count=1. After FILTER+1 further distinct lines have been issued, rehint 0x2000 -> request reissued.
- Overflow, ready=0: DEPTH+3 distinct lines -> occupancy=DEPTH, drop_count=3, and the head stays at the first address.
- Full with simultaneous pop: queue full, assert ready in the same cycle a new distinct hint is in stage 1 -> hint accepted, occupancy stays DEPTH, drop_count unchanged.
- Register control: write PREFETCH_QUEUE_ENABLE=0 with 3 entries queued -> pf_req_valid=0 next cycle, occupancy=0; hints ignored. Write CLR_STATS -> both counters 0. Assert rst with entries queued -> all outputs return to reset values.
